// File: rtl/mem_bridge_master_pkg.sv
// Shared definitions for the MainBus memory bridge initiator:
// FSM state encodings, strobe active levels and bus direction codes.
package mem_bridge_master_pkg;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD       = 2'd1,
    ST_RD_DRAIN = 2'd2,
    ST_WR       = 2'd3
  } mb_state_e;

  // Memory strobes are active-low
  localparam logic MB_STROBE_ON  = 1'b0;
  localparam logic MB_STROBE_OFF = 1'b1;

  // MemBridge_Dir encodings
  localparam logic MB_DIR_WR = 1'b0;  // MainBus -> memory
  localparam logic MB_DIR_RD = 1'b1;  // memory -> MainBus

  // True when an active-low strobe level is asserted
  function automatic logic strobe_active(input logic level);
    return (level == MB_STROBE_ON);
  endfunction

endpackage

// File: rtl/mem_burst_counter.sv
// Burst address register and beat down-counter.
// load captures a new burst; step consumes one beat. When both are high in
// the same cycle the first beat is consumed straight from the load values.
module mem_burst_counter #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  cnt_r;

  // Address advances and beat count drops once per issued beat; address wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      cnt_r  <= {LEN_W{1'b0}};
    end else if (load && step) begin
      addr_r <= load_addr + ADDR_ONE;
      cnt_r  <= load_len - LEN_ONE;
    end else if (load) begin
      addr_r <= load_addr;
      cnt_r  <= load_len;
    end else if (step) begin
      addr_r <= addr_r + ADDR_ONE;
      cnt_r  <= cnt_r - LEN_ONE;
    end else begin
      addr_r <= addr_r;
      cnt_r  <= cnt_r;
    end
  end

  assign cur_addr = addr_r;
  assign last     = (cnt_r == {LEN_W{1'b0}});

endmodule

// File: rtl/mem_bridge_master.sv
// MainBus-side initiator for the RAM/ROM block. Turns single/burst requests
// into registered memory strobes and returns read data with fixed latency
// (beat decided in cycle N -> rsp_valid in cycle N+3).
module mem_bridge_master
  import mem_bridge_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy,
  output logic [ADDR_W-1:0] AddrBus,
  output logic [DATA_W-1:0] MainBusOut,
  input  logic [DATA_W-1:0] MainBusIn,
  output logic              MemBridge_Load,
  output logic              MemBridge_Assert,
  output logic              MemBridge_Dir
);

  mb_state_e         state_r;
  logic              mb_load_r;
  logic              mb_assert_r;
  logic              mb_dir_r;
  logic [ADDR_W-1:0] addr_bus_r;
  logic [DATA_W-1:0] main_bus_out_r;
  logic              wr_done_r;

  logic [1:0]        pipe_vld_r;
  logic [1:0]        pipe_last_r;
  logic              rsp_valid_r;
  logic              rsp_last_r;
  logic [DATA_W-1:0] rsp_data_r;

  logic              accept_s;
  logic              rd_issue_s;
  logic              wr_issue_s;
  logic              beat_last_s;
  logic [ADDR_W-1:0] beat_addr_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic              cnt_last_s;

  mem_burst_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_s),
    .step      (rd_issue_s | wr_issue_s),
    .load_addr (req_addr),
    .load_len  (req_len),
    .cur_addr  (cur_addr_s),
    .last      (cnt_last_s)
  );

  // Beat decision for this cycle; a read issues its first beat in the accept cycle
  always_comb begin
    accept_s    = 1'b0;
    rd_issue_s  = 1'b0;
    wr_issue_s  = 1'b0;
    beat_last_s = 1'b0;
    beat_addr_s = cur_addr_s;
    case (state_r)
      ST_IDLE: begin
        accept_s    = req_valid;
        rd_issue_s  = req_valid & ~req_write;
        beat_last_s = (req_len == {LEN_W{1'b0}});
        beat_addr_s = req_addr;
      end
      ST_RD: begin
        rd_issue_s  = 1'b1;
        beat_last_s = cnt_last_s;
      end
      ST_WR: begin
        wr_issue_s  = wd_valid;
        beat_last_s = cnt_last_s;
      end
      default: begin
        beat_last_s = 1'b0;
      end
    endcase
  end

  // Sequencer with registered memory strobes, address and write data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      mb_load_r      <= MB_STROBE_OFF;
      mb_assert_r    <= MB_STROBE_OFF;
      mb_dir_r       <= MB_DIR_WR;
      addr_bus_r     <= {ADDR_W{1'b0}};
      main_bus_out_r <= {DATA_W{1'b0}};
      wr_done_r      <= 1'b0;
    end else begin
      mb_load_r   <= MB_STROBE_OFF;
      mb_assert_r <= MB_STROBE_OFF;
      wr_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (req_write) begin
              state_r <= ST_WR;
            end else begin
              mb_assert_r <= MB_STROBE_ON;
              mb_dir_r    <= MB_DIR_RD;
              addr_bus_r  <= beat_addr_s;
              state_r     <= beat_last_s ? ST_RD_DRAIN : ST_RD;
            end
          end
        end
        ST_RD: begin
          mb_assert_r <= MB_STROBE_ON;
          mb_dir_r    <= MB_DIR_RD;
          addr_bus_r  <= beat_addr_s;
          if (beat_last_s) begin
            state_r <= ST_RD_DRAIN;
          end
        end
        ST_RD_DRAIN: begin
          // Final beat has left stage 0; it reaches rsp as IDLE is entered
          if (!pipe_vld_r[0]) begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (wr_issue_s) begin
            mb_load_r      <= MB_STROBE_ON;
            mb_dir_r       <= MB_DIR_WR;
            addr_bus_r     <= beat_addr_s;
            main_bus_out_r <= wd_data;
            if (beat_last_s) begin
              state_r   <= ST_IDLE;
              wr_done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-valid/last pipe tracking strobe and memory latency, then data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r  <= 2'b00;
      pipe_last_r <= 2'b00;
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
    end else begin
      pipe_vld_r  <= {pipe_vld_r[0], rd_issue_s};
      pipe_last_r <= {pipe_last_r[0], rd_issue_s & beat_last_s};
      rsp_valid_r <= pipe_vld_r[1];
      rsp_last_r  <= pipe_vld_r[1] & pipe_last_r[1];
      if (pipe_vld_r[1]) begin
        rsp_data_r <= MainBusIn;
      end
    end
  end

  assign req_ready        = (state_r == ST_IDLE);
  assign wd_ready         = (state_r == ST_WR);
  assign busy             = (state_r != ST_IDLE) | (|pipe_vld_r);
  assign rsp_valid        = rsp_valid_r;
  assign rsp_last         = rsp_last_r;
  assign rsp_data         = rsp_data_r;
  assign wr_done          = wr_done_r;
  assign AddrBus          = addr_bus_r;
  assign MainBusOut       = main_bus_out_r;
  assign MemBridge_Load   = mb_load_r;
  assign MemBridge_Assert = mb_assert_r;
  assign MemBridge_Dir    = mb_dir_r;

endmodule
